mux_nch_seq: RTL

Parametrised, registered N-channel WIDTH-bit multiplexer. It succeeds the 4-bit 2:1 combinational mux set.
- Manual mode: an external select picks the channel.
- Scan mode: an internal round-robin scanner steps through channels, holding each for DWELL enabled cycles.
- Outputs are registered and qualified by a valid flag. The block sits between the per-channel data sources and a single downstream consumer.

---
 rtl/mux_nch_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux_nch_seq.sv
// Registered N-channel mux with manual select and round-robin scan modes.
// Outputs are registered; f_valid qualifies f, sel_err flags an illegal manual select.
module mux_nch_seq #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   f,
    output logic               f_valid,
    output logic [SELW-1:0]    cur_sel,
    output logic               sel_err
);

    localparam int NSEL = 1 << SELW;
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0]   CMAX = CW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);
    localparam logic [SELW:0]   NL   = (SELW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t          st;
    logic [WIDTH-1:0] ch [NSEL];
    logic [SELW-1:0] ptr;
    logic [CW-1:0]   cnt;
    logic            sel_ok;

    // Unpack channels; unused select codes read as zero so indexing stays in range.
    for (genvar k = 0; k < NSEL; k++) begin : g_ch
        if (k < N) begin : g_use
            assign ch[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch[k] = '0;
        end
    end

    assign sel_ok = ({1'b0, sel} < NL);

    // Operating state is a pure decode of en and mode, so transitions cost no latency.
    always_comb begin
        st = IDLE;
        if (en) begin
            st = mode ? SCAN : MAN;
        end
    end

    // ptr is the channel sampled next in scan; cur_sel reports the channel now on f.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f       <= '0;
            f_valid <= 1'b0;
            cur_sel <= '0;
            sel_err <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            case (st)
                MAN: begin
                    if (sel_ok) begin
                        f       <= ch[sel];
                        cur_sel <= sel;
                        ptr     <= sel;
                        cnt     <= '0;
                        f_valid <= 1'b1;
                        sel_err <= 1'b0;
                    end else begin
                        f_valid <= 1'b0;
                        sel_err <= 1'b1;
                    end
                end
                SCAN: begin
                    f       <= ch[ptr];
                    cur_sel <= ptr;
                    f_valid <= 1'b1;
                    sel_err <= 1'b0;
                    if (cnt == CMAX) begin
                        cnt <= '0;
                        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    f_valid <= 1'b0;
                    sel_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
